fixed_vec_addsub: RTL and testbench

Parametrised, pipelined, multi-lane signed fixed-point adder/subtractor for the Execution stage. It supersedes the single-lane combinational ripple adder. Additions over that adder:
- per-transaction add/sub mode
- optional saturation with per-lane overflow flags
- a two-stage valid/ready pipeline
- a saturating overflow event counter

Default format is Q7.8 (16-bit two's complement), 4 lanes.

---
 rtl/fixed_vec_addsub.sv | 158 +++++++++++++++
 tb/tb_fixed_vec_addsub.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fixed_vec_addsub.sv
// Multi-lane signed fixed-point adder/subtractor behind a two-stage valid/ready pipeline,
// with optional per-transaction saturation, per-lane overflow flags and a saturating overflow counter.
module fixed_vec_addsub #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8,
    parameter int LANES      = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          op,
    input  logic                          sat_en,
    input  logic [LANES*DATA_WIDTH-1:0]   a,
    input  logic [LANES*DATA_WIDTH-1:0]   b,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [LANES*DATA_WIDTH-1:0]   out_data,
    output logic [LANES-1:0]              out_ovf,
    output logic [CNT_WIDTH-1:0]          ovf_count,
    input  logic                          cnt_clr
);

    // Handshake: a transfer happens on a rising edge where valid && ready. Each stage
    // advances when it is empty or the stage after it advances; in_ready is therefore
    // combinational from out_ready, and an empty stage fills even when the output stalls.

    localparam int W  = DATA_WIDTH;
    localparam int PW = $clog2(LANES + 1);
    localparam int SW = CNT_WIDTH + PW;

    localparam logic [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

    // The binary point position does not change the arithmetic; reject nonsense formats.
    if (FRAC_BITS < 0 || FRAC_BITS >= DATA_WIDTH) begin : g_bad_frac
        $error("FRAC_BITS must lie in [0, DATA_WIDTH)");
    end

    logic                      adv1;
    logic                      adv2;
    logic                      xfer_out;

    logic                      v1_q,   v1_d;
    logic                      sat1_q, sat1_d;
    logic [LANES-1:0][W:0]     raw_q,  raw_d;

    logic                      v2_q,   v2_d;
    logic [LANES*W-1:0]        data_q, data_d;
    logic [LANES-1:0]          ovf_q,  ovf_d;

    logic [CNT_WIDTH-1:0]      cnt_q,  cnt_d;
    logic [PW-1:0]             pop;
    logic [SW-1:0]             sum;

    logic [W:0]                a_ext;
    logic [W:0]                b_ext;
    logic [W:0]                b_opnd;
    logic                      lane_ovf;

    always_comb begin
        adv2 = !v2_q || out_ready;
        adv1 = !v1_q || adv2;
    end

    assign in_ready = adv1;
    assign xfer_out = v2_q && out_ready;

    // Stage 1: sign-extend by one bit so the raw sum never loses information.
    always_comb begin
        v1_d   = v1_q;
        sat1_d = sat1_q;
        raw_d  = raw_q;
        a_ext  = '0;
        b_ext  = '0;
        b_opnd = '0;
        if (adv1) begin
            v1_d = in_valid;
            if (in_valid) begin
                sat1_d = sat_en;
                for (int i = 0; i < LANES; i++) begin
                    a_ext    = {a[i*W+W-1], a[i*W +: W]};
                    b_ext    = {b[i*W+W-1], b[i*W +: W]};
                    b_opnd   = op ? ~b_ext : b_ext;
                    raw_d[i] = a_ext + b_opnd + {{W{1'b0}}, op};
                end
            end
        end
    end

    // Stage 2: overflow when the extra sign bit disagrees with the result sign bit.
    always_comb begin
        v2_d     = v2_q;
        data_d   = data_q;
        ovf_d    = ovf_q;
        lane_ovf = 1'b0;
        if (adv2) begin
            v2_d = v1_q;
            if (v1_q) begin
                for (int i = 0; i < LANES; i++) begin
                    lane_ovf = raw_q[i][W] ^ raw_q[i][W-1];
                    ovf_d[i] = lane_ovf;
                    if (sat1_q && lane_ovf) begin
                        data_d[i*W +: W] = raw_q[i][W] ? SAT_MIN : SAT_MAX;
                    end else begin
                        data_d[i*W +: W] = raw_q[i][W-1:0];
                    end
                end
            end
        end
    end

    // Overflow counter: clear beats increment; the increment saturates instead of wrapping.
    always_comb begin
        pop = '0;
        for (int i = 0; i < LANES; i++) begin
            pop = pop + PW'(ovf_q[i]);
        end
        sum   = {{PW{1'b0}}, cnt_q} + {{CNT_WIDTH{1'b0}}, pop};
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (xfer_out) begin
            if (sum[SW-1:CNT_WIDTH] != '0) begin
                cnt_d = '1;
            end else begin
                cnt_d = sum[CNT_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q   <= 1'b0;
            sat1_q <= 1'b0;
            raw_q  <= '0;
            v2_q   <= 1'b0;
            data_q <= '0;
            ovf_q  <= '0;
            cnt_q  <= '0;
        end else begin
            v1_q   <= v1_d;
            sat1_q <= sat1_d;
            raw_q  <= raw_d;
            v2_q   <= v2_d;
            data_q <= data_d;
            ovf_q  <= ovf_d;
            cnt_q  <= cnt_d;
        end
    end

    assign out_valid = v2_q;
    assign out_data  = data_q;
    assign out_ovf   = ovf_q;
    assign ovf_count = cnt_q;

endmodule

// File: tb/tb_fixed_vec_addsub.sv
// Bench for fixed_vec_addsub: directed cases plus randomized traffic with random backpressure,
// scored against an integer-arithmetic reference model; a second instance exercises a 4-bit counter.
module tb_fixed_vec_addsub;

    localparam int W    = 16;
    localparam int L    = 4;
    localparam int DW   = L * W;
    localparam int MAXV = (1 << (W - 1)) - 1;
    localparam int MINV = -(1 << (W - 1));
    localparam int CMAX16 = 65535;
    localparam int CMAX4  = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          op;
    logic          sat_en;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          out_ready;
    logic          cnt_clr;

    logic          in_ready,  in_ready4;
    logic          out_valid, out_valid4;
    logic [DW-1:0] out_data,  out_data4;
    logic [L-1:0]  out_ovf,   out_ovf4;
    logic [15:0]   ovf_count;
    logic [3:0]    ovf_count4;

    int n_checks = 0;
    int n_fail   = 0;
    int n_out    = 0;
    logic chk_en = 1'b0;
    logic saw_stall = 1'b0;

    logic [DW+L-1:0] exp_q[$];
    int cnt_m  = 0;
    int cnt4_m = 0;

    logic          held_v = 1'b0;
    logic [DW-1:0] held_d;
    logic [L-1:0]  held_o;

    fixed_vec_addsub #(.DATA_WIDTH(W), .FRAC_BITS(8), .LANES(L), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .sat_en(sat_en),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ovf(out_ovf), .ovf_count(ovf_count), .cnt_clr(cnt_clr)
    );

    fixed_vec_addsub #(.DATA_WIDTH(W), .FRAC_BITS(8), .LANES(L), .CNT_WIDTH(4)) dut_c4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4), .op(op), .sat_en(sat_en),
        .a(a), .b(b), .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
        .out_ovf(out_ovf4), .ovf_count(ovf_count4), .cnt_clr(cnt_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: each lane as a plain signed integer, then clamp or wrap to W bits.
    function automatic logic [DW+L-1:0] model(input logic [DW-1:0] av, input logic [DW-1:0] bv,
                                              input logic o, input logic s);
        logic [DW-1:0] d;
        logic [L-1:0]  f;
        logic [W-1:0]  la, lb;
        int sa, sb, r;
        d = '0;
        f = '0;
        for (int i = 0; i < L; i++) begin
            la = av[i*W +: W];
            lb = bv[i*W +: W];
            sa = int'($signed(la));
            sb = int'($signed(lb));
            r  = o ? sa - sb : sa + sb;
            f[i] = (r > MAXV) || (r < MINV);
            if (f[i] && s) r = (r > MAXV) ? MAXV : MINV;
            d[i*W +: W] = r[W-1:0];
        end
        return {f, d};
    endfunction

    function automatic logic [DW-1:0] rep(input logic [W-1:0] x);
        return {L{x}};
    endfunction

    function automatic logic [W-1:0] rand_lane();
        logic [W-1:0] v;
        case ($urandom_range(0, 5))
            0: v = 16'h8000;
            1: v = 16'h7FFF;
            2: v = 16'h0000;
            3: v = 16'hFFFF;
            default: v = W'($urandom);
        endcase
        return v;
    endfunction

    // Scoreboard: runs on the falling edge, ahead of the rising edge it predicts.
    always @(negedge clk) begin
        logic [DW+L-1:0] e;
        int pc;
        logic exp_ir;
        if (chk_en) begin
            check_eq("ovf_count", ovf_count, cnt_m);
            check_eq("ovf_count_w4", ovf_count4, cnt4_m);
            if (rst) begin
                exp_q.delete();
                cnt_m  = 0;
                cnt4_m = 0;
                held_v = 1'b0;
            end else begin
                if (held_v) begin
                    check_eq("hold_valid", out_valid, 1);
                    check_eq("hold_data", out_data, held_d);
                    check_eq("hold_ovf", out_ovf, held_o);
                end
                exp_ir = !(exp_q.size() >= 2 && !out_ready);
                check_eq("in_ready", in_ready, exp_ir);
                check_eq("in_ready_w4", in_ready4, exp_ir);
                if (exp_q.size() == 0) begin
                    check_eq("out_valid_idle", out_valid, 0);
                    check_eq("out_valid_idle_w4", out_valid4, 0);
                end
                if (exp_q.size() >= 2) check_eq("out_valid_full", out_valid, 1);
                held_v = out_valid && !out_ready;
                held_d = out_data;
                held_o = out_ovf;
                pc = 0;
                if (out_valid && out_ready && exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check_eq("out_data", out_data, e[DW-1:0]);
                    check_eq("out_ovf", out_ovf, e[DW+L-1:DW]);
                    check_eq("out_data_w4", out_data4, e[DW-1:0]);
                    pc = $countones(e[DW+L-1:DW]);
                    n_out++;
                end
                if (in_valid && in_ready) exp_q.push_back(model(a, b, op, sat_en));
                if (cnt_clr) begin
                    cnt_m  = 0;
                    cnt4_m = 0;
                end else begin
                    cnt_m  = (cnt_m + pc > CMAX16) ? CMAX16 : cnt_m + pc;
                    cnt4_m = (cnt4_m + pc > CMAX4) ? CMAX4 : cnt4_m + pc;
                end
            end
        end
    end

    task automatic send(input logic [DW-1:0] av, input logic [DW-1:0] bv, input logic o, input logic s);
        int n = 0;
        logic acc = 1'b0;
        a = av; b = bv; op = o; sat_en = s; in_valid = 1'b1;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready;
            if (!acc) saw_stall = 1'b1;
            n++;
            @(posedge clk);
            #1;
        end
        if (!acc) check_eq("send_timeout", acc, 1);
        in_valid = 1'b0;
    endtask

    task automatic get_result(output logic [DW-1:0] d, output logic [L-1:0] f);
        int n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (out_valid) break;
        end
        check_eq("latency", n, 2);
        d = out_data;
        f = out_ovf;
        @(posedge clk);
        #1;
    endtask

    task automatic xact(input logic [DW-1:0] av, input logic [DW-1:0] bv, input logic o,
                        input logic s, output logic [DW-1:0] d, output logic [L-1:0] f);
        send(av, bv, o, s);
        get_result(d, f);
    endtask

    task automatic check_cnt(input string tag, input int e16, input int e4);
        @(negedge clk);
        check_eq({tag, "_cnt"}, ovf_count, e16);
        check_eq({tag, "_cnt_w4"}, ovf_count4, e4);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [DW-1:0] d;
        logic [L-1:0]  f;
        logic          done;
        int            n;

        rst = 1'b1; in_valid = 1'b0; op = 1'b0; sat_en = 1'b0;
        a = '0; b = '0; out_ready = 1'b1; cnt_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_data", out_data, 0);
        check_eq("rst_out_ovf", out_ovf, 0);
        check_eq("rst_ovf_count", ovf_count, 0);
        chk_en = 1'b1;
        @(posedge clk);
        #1;

        // 1.5 + 2.25 in Q7.8
        xact({48'h0, 16'h0180}, {48'h0, 16'h0240}, 1'b0, 1'b1, d, f);
        check_eq("basic_lane0", d[15:0], 16'h03C0);
        check_eq("basic_ovf", f, 4'b0000);
        check_cnt("basic", 0, 0);

        xact({32'h0, 16'h7F00, 16'h0}, {32'h0, 16'h0100, 16'h0}, 1'b0, 1'b1, d, f);
        check_eq("possat_lane1", d[31:16], 16'h7FFF);
        check_eq("possat_ovf", f, 4'b0010);
        check_cnt("possat", 1, 1);

        xact({32'h0, 16'h7F00, 16'h0}, {32'h0, 16'h0100, 16'h0}, 1'b0, 1'b0, d, f);
        check_eq("poswrap_lane1", d[31:16], 16'h8000);
        check_eq("poswrap_ovf", f, 4'b0010);
        check_cnt("poswrap", 2, 2);

        xact(rep(16'h8000), rep(16'h0100), 1'b1, 1'b1, d, f);
        check_eq("negsat_data", d, rep(16'h8000));
        check_eq("negsat_ovf", f, 4'b1111);
        check_cnt("negsat", 6, 6);

        xact(rep(16'h0000), rep(16'h8000), 1'b1, 1'b1, d, f);
        check_eq("submin_data", d, rep(16'h7FFF));
        check_eq("submin_ovf", f, 4'b1111);
        check_cnt("submin", 10, 10);

        for (int i = 0; i < 5; i++) begin
            xact(rep(16'h7FFF), rep(16'h7FFF), 1'b0, 1'b1, d, f);
        end
        check_cnt("cnt_sat", 30, 15);

        // clear lands on the same edge as an overflowing output transfer
        send(rep(16'h8000), rep(16'h0001), 1'b1, 1'b0);
        @(posedge clk);
        #1 cnt_clr = 1'b1;
        @(posedge clk);
        #1 cnt_clr = 1'b0;
        check_cnt("clr_wins", 0, 0);

        // five back-to-back transactions, output stalled for four cycles
        n = n_out;
        saw_stall = 1'b0;
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    send(rep(W'((i + 1) * 16'h0123)), rep(16'h0011), i[0], 1'b1);
                end
            end
            begin
                out_ready = 1'b1;
                @(posedge clk);
                #1;
                @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(posedge clk);
        #1;
        check_eq("bp_stalled", saw_stall, 1);
        check_eq("bp_outputs", n_out - n, 5);

        // randomized traffic with random backpressure
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    send({rand_lane(), rand_lane(), rand_lane(), rand_lane()},
                         {rand_lane(), rand_lane(), rand_lane(), rand_lane()},
                         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                    repeat ($urandom_range(0, 1)) begin
                        @(posedge clk);
                        #1;
                    end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(posedge clk);
        #1;
        check_eq("drain", exp_q.size(), 0);

        // reset while both stages hold a transaction
        out_ready = 1'b0;
        send(rep(16'h7FFF), rep(16'h0001), 1'b0, 1'b1);
        send(rep(16'h8000), rep(16'h0001), 1'b1, 1'b1);
        @(negedge clk);
        check_eq("full_in_ready", in_ready, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("midrst_out_valid", out_valid, 0);
        check_eq("midrst_ovf_count", ovf_count, 0);
        check_eq("midrst_ovf_count_w4", ovf_count4, 0);
        @(posedge clk);
        #1 out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check_eq("midrst_no_output", n_out - n - 5 - 300, 0);

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
